// File: rtl/uart_tx_feeder.sv
// Byte FIFO and launch sequencer feeding a UART transmitter.
// One TxEn pulse per byte, TxDone handshake, watchdog abort.
module uart_tx_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned EN_CYCLES = 2,
    parameter int unsigned TIMEOUT   = 1000000,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          WrEn,
    input  logic [7:0]    WrData,
    output logic          Full,
    output logic          Empty,
    output logic [CW-1:0] Count,
    output logic [7:0]    TxData,
    output logic          TxEn,
    input  logic          TxDone,
    output logic          Busy,
    output logic          Overflow,
    output logic          TimeoutErr,
    input  logic          ErrClr
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [EW-1:0] EN_LAST  = EW'(EN_CYCLES - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        WAIT_CLR  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [7:0]    tx_data_q;
    logic          tx_en_q;
    logic [EW-1:0] en_cnt;
    logic [WW-1:0] wd_cnt;
    logic          done_m;
    logic          done_s;
    logic          ovf_q;
    logic          tmo_q;

    logic          full_w;
    logic          empty_w;
    logic          push;
    logic          pop;
    logic          in_wait;
    logic          en_last;
    logic          wd_expired;
    logic          tx_en_d;

    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    assign push    = WrEn && !full_w;
    assign en_last = (en_cnt == EN_LAST);

    // Bring the Tick-domain done flag into Clk before any use.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            done_m <= 1'b0;
            done_s <= 1'b0;
        end else begin
            done_m <= TxDone;
            done_s <= done_m;
        end
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; watchdog abort overrides the handshake.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!empty_w) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (en_last) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (wd_expired) begin
                    state_nxt = IDLE;
                end else if (done_s) begin
                    state_nxt = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (wd_expired || !done_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode: pop in IDLE, watchdog window, registered TxEn.
    always_comb begin
        pop        = 1'b0;
        in_wait    = 1'b0;
        wd_expired = 1'b0;
        tx_en_d    = (state_nxt == LAUNCH);
        unique case (state)
            IDLE: begin
                pop = !empty_w;
            end
            WAIT_DONE, WAIT_CLR: begin
                in_wait    = 1'b1;
                wd_expired = (wd_cnt == WD_LAST);
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= WrData;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Byte in flight and launch pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
        end else begin
            if (pop) begin
                tx_data_q <= mem[rd_ptr];
            end
            tx_en_q <= tx_en_d;
        end
    end

    // LAUNCH duration counter, restarted on each pop.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            en_cnt <= '0;
        end else if (pop) begin
            en_cnt <= '0;
        end else if (state == LAUNCH && !en_last) begin
            en_cnt <= en_cnt + EW'(1);
        end
    end

    // Watchdog: counts cycles spent waiting on the transmitter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wd_cnt <= '0;
        end else if (pop) begin
            wd_cnt <= '0;
        end else if (in_wait) begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // Sticky error flags; a new set beats a clear.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            if (WrEn && full_w) begin
                ovf_q <= 1'b1;
            end else if (ErrClr) begin
                ovf_q <= 1'b0;
            end
            if (wd_expired) begin
                tmo_q <= 1'b1;
            end else if (ErrClr) begin
                tmo_q <= 1'b0;
            end
        end
    end

    assign Full       = full_w;
    assign Empty      = empty_w;
    assign Count      = count_q;
    assign TxData     = tx_data_q;
    assign TxEn       = tx_en_q;
    assign Busy       = (state != IDLE);
    assign Overflow   = ovf_q;
    assign TimeoutErr = tmo_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder.
// DEPTH=16, EN_CYCLES=2, TIMEOUT=100.
module tb_uart_tx_feeder;

    logic       Clk;
    logic       Rst;
    logic       WrEn;
    logic [7:0] WrData;
    logic       Full;
    logic       Empty;
    logic [4:0] Count;
    logic [7:0] TxData;
    logic       TxEn;
    logic       TxDone;
    logic       Busy;
    logic       Overflow;
    logic       TimeoutErr;
    logic       ErrClr;

    int n_chk  = 0;
    int n_fail = 0;

    uart_tx_feeder #(
        .DEPTH(16),
        .EN_CYCLES(2),
        .TIMEOUT(100)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .WrEn(WrEn),
        .WrData(WrData),
        .Full(Full),
        .Empty(Empty),
        .Count(Count),
        .TxData(TxData),
        .TxEn(TxEn),
        .TxDone(TxDone),
        .Busy(Busy),
        .Overflow(Overflow),
        .TimeoutErr(TimeoutErr),
        .ErrClr(ErrClr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: raise TxDone, hold it, drop it, wait for IDLE.
    task automatic handshake(input string tag);
        int rel;
        int n;
        rel = 0;
        TxDone = 1'b1;
        repeat (6) begin
            tick();
            if (TxEn) rel++;
        end
        check({tag, "_norelaunch"}, rel, 0);
        check({tag, "_busy_clr"}, Busy, 1'b1);
        TxDone = 1'b0;
        n = 0;
        while (Busy && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, Busy, 1'b0);
    endtask

    // Expect one launch of exp (TxEn low or at its first high sample).
    task automatic serve(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (!TxEn && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_en"}, TxEn, 1'b1);
        check({tag, "_data"}, TxData, exp);
        n = 0;
        while (TxEn && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_width"}, n, 2);
        handshake(tag);
    endtask

    initial begin
        int n;
        int rel;
        Rst    = 1'b1;
        WrEn   = 1'b0;
        WrData = 8'h00;
        TxDone = 1'b0;
        ErrClr = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        check("rst_empty", Empty, 1'b1);
        check("rst_full", Full, 1'b0);
        check("rst_count", Count, 0);
        check("rst_txen", TxEn, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_txdata", TxData, 8'h00);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_tmo", TimeoutErr, 1'b0);

        // Single byte: launch latency and handshake.
        WrEn   = 1'b1;
        WrData = 8'hA5;
        tick();
        WrEn = 1'b0;
        check("one_count", Count, 1);
        check("one_en_early", TxEn, 1'b0);
        tick();
        check("one_en_lat", TxEn, 1'b1);
        check("one_popped", Count, 0);
        serve(8'hA5, "one");

        // Back-to-back pushes.
        WrEn   = 1'b1;
        WrData = 8'h55;
        tick();
        check("b2b_c1", Count, 1);
        WrData = 8'hAA;
        tick();
        check("b2b_c2", Count, 1);
        check("b2b_en0", TxEn, 1'b1);
        check("b2b_d0", TxData, 8'h55);
        WrData = 8'h0F;
        tick();
        WrEn = 1'b0;
        check("b2b_c3", Count, 2);
        check("b2b_en0b", TxEn, 1'b1);
        tick();
        check("b2b_en0_off", TxEn, 1'b0);
        handshake("b2b0");
        serve(8'hAA, "b2b1");
        check("b2b_c4", Count, 1);
        serve(8'h0F, "b2b2");
        check("b2b_c5", Count, 0);
        check("b2b_empty", Empty, 1'b1);

        // Fill: one in flight plus 16 queued, then one extra.
        WrEn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            WrData = 8'(8'h10 + i);
            tick();
        end
        check("ov_count", Count, 16);
        check("ov_full", Full, 1'b1);
        check("ov_flag0", Overflow, 1'b0);
        WrData = 8'hEE;
        tick();
        WrEn = 1'b0;
        check("ov_flag1", Overflow, 1'b1);
        check("ov_count2", Count, 16);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        check("ov_clr", Overflow, 1'b0);
        WrEn   = 1'b1;
        ErrClr = 1'b1;
        WrData = 8'hEF;
        tick();
        WrEn   = 1'b0;
        ErrClr = 1'b0;
        check("ov_setwins", Overflow, 1'b1);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        check("ov_clr2", Overflow, 1'b0);
        handshake("ov0");
        for (int i = 1; i < 17; i++) begin
            serve(8'(8'h10 + i), $sformatf("ov%0d", i));
        end
        check("ov_drained", Empty, 1'b1);

        // Timeout with TxDone stuck low.
        WrEn   = 1'b1;
        WrData = 8'h77;
        tick();
        WrData = 8'h88;
        tick();
        WrEn = 1'b0;
        n = 0;
        while (!TxEn && n < 20) begin
            tick();
            n++;
        end
        check("tmo_data", TxData, 8'h77);
        n = 0;
        while (TxEn && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!TimeoutErr && n < 150) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 100);
        check("tmo_idle", Busy, 1'b0);
        serve(8'h88, "tmo_next");
        check("tmo_sticky", TimeoutErr, 1'b1);
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        check("tmo_clr", TimeoutErr, 1'b0);

        // Reset mid-frame drops everything.
        WrEn   = 1'b1;
        WrData = 8'hC3;
        tick();
        WrData = 8'h3C;
        tick();
        WrEn = 1'b0;
        Rst  = 1'b1;
        tick();
        Rst = 1'b0;
        check("mid_empty", Empty, 1'b1);
        check("mid_busy", Busy, 1'b0);
        check("mid_txen", TxEn, 1'b0);
        check("mid_txdata", TxData, 8'h00);
        tick();
        tick();
        check("mid_nolaunch", TxEn, 1'b0);

        // TxDone stuck high: frame times out in WAIT_CLR.
        TxDone = 1'b1;
        tick();
        tick();
        tick();
        WrEn   = 1'b1;
        WrData = 8'h99;
        tick();
        WrEn = 1'b0;
        n = 0;
        while (!TxEn && n < 20) begin
            tick();
            n++;
        end
        check("hi_data", TxData, 8'h99);
        n = 0;
        while (TxEn && n < 20) begin
            tick();
            n++;
        end
        ErrClr = 1'b1;
        n = 0;
        while (!TimeoutErr && n < 150) begin
            tick();
            n++;
        end
        check("hi_cycles", n, 100);
        check("hi_idle", Busy, 1'b0);
        tick();
        check("hi_clr", TimeoutErr, 1'b0);
        ErrClr = 1'b0;
        rel = 0;
        repeat (30) begin
            tick();
            if (TxEn) rel++;
        end
        check("hi_norelaunch", rel, 0);
        TxDone = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
